// File: rtl/core_pkg.sv
// core_pkg: shared datapath width, reset vector, alignment and address type for the core.
package core_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;
  localparam int IALIGN = 4;
  typedef logic [XLEN-1:0] addr_t;
  function automatic logic is_misaligned(input addr_t a, input int align);
    return |(a & addr_t'(align - 1));
  endfunction
endpackage

// File: rtl/dff_ar.sv
// dff_ar: register with asynchronous active-high reset to a parameterised value.
module dff_ar #(
  parameter int W = 32,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  // an unknown rst falls through to the load path rather than forcing RST_VAL
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= RST_VAL;
    else q <= d;
endmodule

// File: rtl/program_counter.sv
// program_counter: architectural PC register with sequential next address and misalignment flag.
module program_counter
  import core_pkg::*;
#(
  parameter int XLEN = core_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = core_pkg::RESET_VECTOR,
  parameter int IALIGN_BYTES = core_pkg::IALIGN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc_in,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_plus4,
  output logic            pc_misaligned
);
  dff_ar #(.W(XLEN), .RST_VAL(RESET_VECTOR)) u_pc (
    .clk(clk),
    .rst(reset),
    .d  (pc_in),
    .q  (pc_out)
  );
  // masking with IALIGN_BYTES-1 also covers a byte-aligned (IALIGN_BYTES=1) build
  always_comb begin
    pc_plus4      = pc_out + XLEN'(4);
    pc_misaligned = |(pc_out & XLEN'(IALIGN_BYTES - 1));
  end
endmodule

// File: tb/tb_program_counter.sv
// tb_program_counter: directed scoreboard bench for program_counter.
module tb_program_counter;
  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic [31:0] plus4;
    logic        mis;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] pc_in = '0;
  logic [31:0] pc_out, pc_plus4;
  logic        pc_misaligned;
  int          checks = 0;
  int          failures = 0;
  exp_t        sb[$];

  program_counter dut (
    .clk          (clk),
    .reset        (reset),
    .pc_in        (pc_in),
    .pc_out       (pc_out),
    .pc_plus4     (pc_plus4),
    .pc_misaligned(pc_misaligned)
  );

  always #5 clk = ~clk;

  task automatic expect_pc(input string tag, input logic [31:0] pc);
    exp_t e;
    e.tag   = tag;
    e.pc    = pc;
    e.plus4 = pc + 32'd4;
    e.mis   = pc[1:0] != 2'b00;
    sb.push_back(e);
  endtask

  task automatic check();
    exp_t e;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    e = sb.pop_front();
    checks++;
    assert (pc_out === e.pc) else begin
      failures++;
      $error("FAIL %s pc_out observed=%h expected=%h", e.tag, pc_out, e.pc);
    end
    checks++;
    assert (pc_plus4 === e.plus4) else begin
      failures++;
      $error("FAIL %s pc_plus4 observed=%h expected=%h", e.tag, pc_plus4, e.plus4);
    end
    checks++;
    assert (pc_misaligned === e.mis) else begin
      failures++;
      $error("FAIL %s pc_misaligned observed=%b expected=%b", e.tag, pc_misaligned, e.mis);
    end
  endtask

  task automatic load(input string tag, input logic [31:0] v);
    @(negedge clk);
    pc_in = v;
    expect_pc(tag, v);
    @(posedge clk);
    #1 check();
  endtask

  initial begin
    #2 reset = 1'b1;
    expect_pc("reset_async", 32'h0);
    #1 check();
    @(negedge clk);
    reset = 1'b0;
    pc_in = 32'h0;
    expect_pc("load_zero", 32'h0);
    @(posedge clk);
    #1 check();
    load("load_odd", 32'h0000_0001);
    @(negedge clk);
    pc_in = 32'h0000_0040;
    expect_pc("hold", 32'h0000_0001);
    #2 check();
    expect_pc("load_40", 32'h0000_0040);
    @(posedge clk);
    #1 check();
    load("wrap", 32'hFFFF_FFFC);
    load("half_aligned", 32'h0000_0002);
    load("odd_high", 32'h8000_0003);
    load("load_100", 32'h0000_0100);
    @(negedge clk);
    #1 reset = 1'b1;
    expect_pc("reset_mid", 32'h0);
    #1 check();
    reset = 1'b0;
    pc_in = 32'h0000_0008;
    expect_pc("after_reset", 32'h0000_0008);
    @(posedge clk);
    #1 check();
    @(negedge clk);
    reset = 1'b1;
    pc_in = 32'h0000_0200;
    expect_pc("reset_at_edge", 32'h0);
    @(posedge clk);
    #1 check();
    @(negedge clk);
    reset = 1'b0;
    load("resume", 32'h0000_0204);
    load("random_a", 32'h1234_5678);
    load("random_b", 32'hDEAD_BEEE);
    if (sb.size() != 0) begin
      failures++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
